// File: rtl/rw_stage_pkg.sv
// Constants shared by the EX/MA/RW stages: control-bus bit positions, call link register,
// and the position of the destination register field in the instruction word.
package rw_stage_pkg;
  localparam int unsigned CTRL_ISST   = 0;
  localparam int unsigned CTRL_ISLD   = 1;
  localparam int unsigned CTRL_ISWB   = 2;
  localparam int unsigned CTRL_ISCALL = 3;

  localparam logic [3:0]  RA_REG_DEF  = 4'd15;

  localparam int unsigned IR_RD_HI    = 25;
  localparam int unsigned IR_RD_LO    = 22;
endpackage

// File: rtl/rw_stage_wb_select.sv
// Writeback select: derives register-file write data, index and strobe from the latched fields.
module rw_wb_select
  import rw_stage_pkg::*;
#(
  parameter int unsigned     REG_ADDR_W = 4,
  parameter int unsigned     CTRL_W     = 22,
  parameter logic [REG_ADDR_W-1:0] RA_REG = RA_REG_DEF
) (
  input  logic                  valid_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           alu_i,
  input  logic [31:0]           ld_i,
  input  logic [31:0]           ir_i,
  input  logic [CTRL_W-1:0]     ctrl_i,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [31:0]           data_o
);
  logic is_st, is_ld, is_wb, is_call;
  logic unused_bits;

  assign is_st   = ctrl_i[CTRL_ISST];
  assign is_ld   = ctrl_i[CTRL_ISLD];
  assign is_wb   = ctrl_i[CTRL_ISWB];
  assign is_call = ctrl_i[CTRL_ISCALL];

  // Stores are distinguished only by the absence of isWb; the bit is decoded for trace symmetry.
  assign unused_bits = ^{is_st, ctrl_i[CTRL_W-1:CTRL_ISCALL+1],
                         ir_i[31:IR_RD_HI+1], ir_i[IR_RD_LO-1:0]};

  always_comb begin
    data_o = alu_i;
    if (is_ld)
      data_o = ld_i;
    else if (is_call)
      data_o = pc_i + 32'd4;

    rd_o = is_call ? RA_REG : ir_i[IR_RD_LO +: REG_ADDR_W];
    we_o = valid_i & is_wb;
  end
endmodule

// File: rtl/rw_stage.sv
// Register-writeback pipeline latch: holds one instruction, drives the register-file write
// port / forwarding source, and counts retired instructions.
module rw_stage
  import rw_stage_pkg::*;
#(
  parameter int unsigned           REG_ADDR_W = 4,
  parameter int unsigned           CTRL_W     = 22,
  parameter logic [REG_ADDR_W-1:0] RA_REG     = RA_REG_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  input_RW_valid,
  input  logic [31:0]           input_RW_PC,
  input  logic [31:0]           input_RW_ALU_Result,
  input  logic [31:0]           input_RW_Ld_Result,
  input  logic [31:0]           input_RW_IR,
  input  logic [CTRL_W-1:0]     input_RW_controlBus,
  output logic                  RW_writeEnable,
  output logic [REG_ADDR_W-1:0] RW_rd,
  output logic [31:0]           RW_Data_value,
  output logic                  RW_valid,
  output logic [31:0]           output_RW_IR,
  output logic [31:0]           RW_retired_count
);
  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       ld_q, ld_d;
  logic [31:0]       ir_q, ir_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       count_q, count_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    ld_d    = ld_q;
    ir_d    = ir_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      // Data fields hold on a flush; they are don't-care once valid drops.
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = input_RW_valid;
      pc_d    = input_RW_PC;
      alu_d   = input_RW_ALU_Result;
      ld_d    = input_RW_Ld_Result;
      ir_d    = input_RW_IR;
      ctrl_d  = input_RW_controlBus;
    end

    count_d = count_q;
    if (valid_q && (!stall || flush))
      count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      ir_q    <= '0;
      ctrl_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
    end
  end

  rw_wb_select #(
    .REG_ADDR_W (REG_ADDR_W),
    .CTRL_W     (CTRL_W),
    .RA_REG     (RA_REG)
  ) u_wb_select (
    .valid_i (valid_q),
    .pc_i    (pc_q),
    .alu_i   (alu_q),
    .ld_i    (ld_q),
    .ir_i    (ir_q),
    .ctrl_i  (ctrl_q),
    .we_o    (RW_writeEnable),
    .rd_o    (RW_rd),
    .data_o  (RW_Data_value)
  );

  assign RW_valid         = valid_q;
  assign output_RW_IR     = ir_q;
  assign RW_retired_count = count_q;
endmodule

// File: tb/tb_rw_stage.sv
// Bench for rw_stage: directed vectors, a transaction-level reference model checked every
// negative edge, and literal expectations at key points of the sequence.
module tb_rw_stage;
  localparam logic [21:0] C_ST   = 22'd1;
  localparam logic [21:0] C_LD   = 22'd2;
  localparam logic [21:0] C_WB   = 22'd4;
  localparam logic [21:0] C_CALL = 22'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_alu = '0, in_ld = '0, in_ir = '0;
  logic [21:0] in_ctrl = '0;
  logic        we, rv;
  logic [3:0]  rd;
  logic [31:0] data, ir_out, cnt;

  int total = 0;
  int bad = 0;
  bit preload_pending = 1'b0;

  rw_stage #(.REG_ADDR_W(4), .CTRL_W(22), .RA_REG(4'd15)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .flush               (flush),
    .input_RW_valid      (in_valid),
    .input_RW_PC         (in_pc),
    .input_RW_ALU_Result (in_alu),
    .input_RW_Ld_Result  (in_ld),
    .input_RW_IR         (in_ir),
    .input_RW_controlBus (in_ctrl),
    .RW_writeEnable      (we),
    .RW_rd               (rd),
    .RW_Data_value       (data),
    .RW_valid            (rv),
    .output_RW_IR        (ir_out),
    .RW_retired_count    (cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in writeback, plus the retire tally.
  typedef struct {
    bit          valid;
    logic [31:0] pc, alu, ld, ir;
    logic [21:0] ctrl;
  } instr_t;

  instr_t      m_ins;
  logic [31:0] m_count;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ins   = '{valid: 1'b0, pc: '0, alu: '0, ld: '0, ir: '0, ctrl: '0};
      m_count = '0;
    end else begin
      if (preload_pending) m_count = 32'hFFFF_FFFF;
      if (m_ins.valid && (!stall || flush)) m_count = m_count + 32'd1;
      if (flush)
        m_ins.valid = 1'b0;
      else if (!stall)
        m_ins = '{valid: in_valid, pc: in_pc, alu: in_alu, ld: in_ld, ir: in_ir, ctrl: in_ctrl};
    end
  end

  function automatic logic [31:0] exp_data(instr_t i);
    if (i.ctrl[1]) return i.ld;
    if (i.ctrl[3]) return i.pc + 32'd4;
    return i.alu;
  endfunction

  function automatic logic [3:0] exp_rd(instr_t i);
    return i.ctrl[3] ? 4'd15 : i.ir[25:22];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!preload_pending) begin
        check("m_valid", {31'd0, rv}, {31'd0, m_ins.valid});
        check("m_we", {31'd0, we}, {31'd0, m_ins.valid & m_ins.ctrl[2]});
        check("m_rd", {28'd0, rd}, {28'd0, exp_rd(m_ins)});
        check("m_data", data, exp_data(m_ins));
        check("m_ir", ir_out, m_ins.ir);
        check("m_count", cnt, m_count);
      end
    end
  end

  function automatic logic [31:0] ir_with_rd(logic [3:0] r);
    return {6'd0, r, 22'd0};
  endfunction

  task automatic drive(bit v, logic [31:0] pc, logic [31:0] alu, logic [31:0] ld,
                       logic [3:0] r, logic [21:0] c, bit s, bit f);
    in_valid = v; in_pc = pc; in_alu = alu; in_ld = ld;
    in_ir = ir_with_rd(r); in_ctrl = c; stall = s; flush = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(string name, bit e_we, logic [3:0] e_rd, logic [31:0] e_data, logic [31:0] e_cnt);
    check({name, "_we"}, {31'd0, we}, {31'd0, e_we});
    check({name, "_rd"}, {28'd0, rd}, {28'd0, e_rd});
    check({name, "_data"}, data, e_data);
    check({name, "_cnt"}, cnt, e_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    step(); step();
    lit("reset", 1'b0, 4'd0, 32'd0, 32'd0);
    check("reset_ir", ir_out, 32'd0);
    reset = 1'b0;

    drive(1, 32'h100, 32'h1234, 32'h0, 4'd7, C_WB, 0, 0);
    step();
    lit("alu", 1'b1, 4'd7, 32'h1234, 32'd0);

    drive(1, 32'h104, 32'h5, 32'hDEADBEEF, 4'd2, C_LD | C_WB, 0, 0);
    step();
    lit("load", 1'b1, 4'd2, 32'hDEADBEEF, 32'd1);

    drive(1, 32'hFFFF_FFFC, 32'h77, 32'h88, 4'd4, C_CALL | C_WB, 0, 0);
    step();
    lit("call", 1'b1, 4'd15, 32'h0, 32'd2);

    drive(1, 32'h200, 32'd9, 32'h0, 4'd3, C_WB, 0, 0);
    step();
    lit("cap", 1'b1, 4'd3, 32'd9, 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + i, 32'hA0 + i, 32'hB0 + i, 4'd8 + 4'(i), C_LD | C_WB, 1, 0);
      step();
      lit("stall", 1'b1, 4'd3, 32'd9, 32'd3);
    end
    drive(0, 32'h0, 32'h0, 32'h0, 4'd0, 22'd0, 0, 0);
    step();
    check("release_cnt", cnt, 32'd4);
    check("release_valid", {31'd0, rv}, 32'd0);

    drive(1, 32'h400, 32'h55, 32'h0, 4'd5, C_WB, 0, 0);
    step();
    lit("fl_cap", 1'b1, 4'd5, 32'h55, 32'd4);
    drive(1, 32'h404, 32'h66, 32'h0, 4'd6, C_WB, 1, 1);
    step();
    check("flush_valid", {31'd0, rv}, 32'd0);
    check("flush_we", {31'd0, we}, 32'd0);
    check("flush_cnt", cnt, 32'd5);

    drive(1, 32'h500, 32'h11, 32'h0, 4'd9, C_ST, 0, 0);
    step();
    check("store_we", {31'd0, we}, 32'd0);
    check("store_valid", {31'd0, rv}, 32'd1);
    drive(0, 32'h504, 32'h22, 32'h0, 4'd1, C_WB, 0, 0);
    step();
    check("store_cnt", cnt, 32'd6);
    check("bubble_we", {31'd0, we}, 32'd0);
    step();
    check("bubble_cnt", cnt, 32'd6);

    drive(1, 32'h600, 32'h33, 32'h0, 4'd10, C_WB, 0, 0);
    step();
    drive(1, 32'h604, 32'h44, 32'h0, 4'd11, C_WB, 1, 0);
    step();
    check("pre_rst_valid", {31'd0, rv}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_we", {31'd0, we}, 32'd0);
    check("async_valid", {31'd0, rv}, 32'd0);
    check("async_cnt", cnt, 32'd0);
    check("async_rd", {28'd0, rd}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    drive(1, 32'h700, 32'h99, 32'h0, 4'd6, C_WB, 0, 0);
    step();
    preload_pending = 1'b1;
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    drive(0, 32'h0, 32'h0, 32'h0, 4'd0, 22'd0, 0, 0);
    step();
    preload_pending = 1'b0;
    check("wrap_cnt", cnt, 32'd0);
    step();
    check("wrap_hold", cnt, 32'd0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
